muldiv_ctrl: RTL
================

# muldiv_ctrl

Multiply/divide sequencer that owns all writes into the HI/LO register pair of the MIPS-54 core. Decode issues MULT, MULTU, DIV, DIVU, MTHI and MTLO here. The block runs iterative 32-step shift-add multiply or restoring divide on a shared 64-bit accumulator. It then drives one write strobe cycle into HI/LO and holds `busy` so the pipeline stalls MFHI/MFLO and further mul/div issue.

## Interface
- `WIDTH`, 32, operand and HI/LO width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ena`  in  1  global CPU enable; low freezes all state
- `start`  in  1  op valid from decode, sampled only in IDLE
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 ignored
- `rs_val`  in  WIDTH  rs operand (multiplicand / dividend / MTxx source)
- `rt_val`  in  WIDTH  rt operand (multiplier / divisor)
- `busy`  out  1  registered; high from cycle after acceptance through the WB cycle
- `done`  out  1  one-cycle pulse coincident with write strobes
- `div_zero`  out  1  one-cycle pulse with `done` for DIV/DIVU with rt_val==0
- `hi_data`, `lo_data`  out  WIDTH  write data, stable whenever strobes high
- `hi_we`, `lo_we`  out  1  HI/LO write strobes, one cycle each

## Operation
- States: IDLE, MUL, DIV, FIX, WB.
- IDLE + `ena` + `start` + legal op = acceptance at edge T. Operands are captured at T.
- Signed ops: store the operand signs and take absolute values; operand magnitudes are treated as unsigned 32-bit, so −2^31 becomes 2^31.
- MUL: 32 shift-add iterations into the 64-bit accumulator. FIX negates the 64-bit product if the signs differ. In WB, `hi_data`=acc[63:32], `lo_data`=acc[31:0], and both strobes are high.
- DIV: 32 restoring iterations, with quotient to LO and remainder to HI. FIX negates the quotient if the signs differ and gives the remainder the dividend's sign. −2^31/−1 yields LO=0x80000000, HI=0.
- Divisor zero: IDLE goes straight to WB. HI=rs_val, LO=0xFFFFFFFF, `div_zero` pulses.
- MTHI/MTLO: IDLE to WB; only the matching strobe is asserted, and its data equals the captured rs_val.
- `start` while busy, or with an illegal op: ignored, with no state change.
- `ena` low: state, counter and accumulator hold. `hi_we`, `lo_we`, `done` and `div_zero` are forced to 0. Sequencing resumes on the first `ena`-high cycle.
- Reset values: state IDLE; counter 0; all outputs 0 (`hi_data`/`lo_data` 0, strobes 0, `busy` 0).
- `rst` mid-operation: immediate IDLE, no write strobe, operation discarded.

## Timing
- Acceptance at edge T (cycle numbers assume `ena` continuously high):
  - MUL/DIV: iterations occupy cycles T+1..T+32, FIX is T+33, WB is T+34. `busy` is high T+1..T+34.
  - Divide-by-zero and MTHI/MTLO: WB at T+1, `busy` high during T+1 only.
- Strobes, `done` and data are registered outputs, valid for the whole WB cycle. The HI/LO register samples them within that cycle.
- After WB the block returns to IDLE. The earliest next acceptance is at the edge ending WB (back-to-back: new `busy` the cycle after WB).
- Each `ena`-low cycle extends latency by exactly one cycle.

## Structure
- `muldiv_pkg`: op encodings (OP_MULT…OP_MTLO), state enum, ITER_CNT=32 constant.
- Sub-module `muldiv_core`: 64-bit accumulator, abs/negate logic, one shift-add or restore-subtract step per enable. It is controlled by the FSM in `muldiv_ctrl` through step/mode/fix/load controls.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF, start at T → at T+34 `hi_we`=`lo_we`=`done`=1, HI=0xFFFFFFFE, LO=0x00000001; `busy` high T+1..T+34.
- MULT −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234/0 → at T+1 HI=0x1234, LO=0xFFFFFFFF, `div_zero`=1, `done`=1.
- MTHI 0x12345678 → `hi_we`=1 only at T+1, `lo_we`=0 throughout. A second `start` (MTLO) during a MULT's busy window → no `lo_we` pulse ever.
- `ena` low for 5 cycles from T+10 of a DIVU → WB at T+39, result unchanged. `rst` pulsed at T+12 of a DIV → `busy`=0 immediately, no strobe, next start accepted normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states,
// datapath mode and iteration count.
package muldiv_pkg;

  localparam int ITER_CNT = 32;
  localparam int CNT_W    = $clog2(ITER_CNT);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;

  typedef enum logic [0:0] {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MTLO);
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Decode-side issue port and HI/LO write-back port of the mul/div sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_data;
  logic [WIDTH-1:0] lo_data;
  logic             hi_we;
  logic             lo_we;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, div_zero, hi_data, lo_data, hi_we, lo_we
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, div_zero, hi_data, lo_data, hi_we, lo_we
  );
endinterface

// File: rtl/muldiv_core.sv
// Shared 64-bit accumulator datapath: operand sign stripping, one shift-add or
// restoring-subtract step per step_i, and final sign correction on fix_i.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  mode_e            mode_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             step_i,
  input  logic             fix_i,
  output logic [WIDTH-1:0] hi_fix_o,
  output logic [WIDTH-1:0] lo_fix_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  mode_e              mode_q, mode_d;

  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] prod_s;

  // Operand magnitudes and per-step arithmetic.
  always_comb begin
    a_mag_s    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag_s    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    // Multiplier sits in the low half and is consumed LSB first.
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Partial remainder shifted left by one is acc_q[2W-1:W-1]; it stays below 2*divisor.
    div_ge_s   = (acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, b_q});
    div_diff_s = acc_q[2*WIDTH-2:WIDTH-1] - b_q;
    prod_s     = neg_res_q ? -acc_q : acc_q;
  end

  // Sign-corrected result, consumed both by the fix step and the write-back registers.
  always_comb begin
    if (mode_q == MODE_MUL) begin
      hi_fix_o = prod_s[2*WIDTH-1:WIDTH];
      lo_fix_o = prod_s[WIDTH-1:0];
    end else begin
      hi_fix_o = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      lo_fix_o = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  // Accumulator next-state selection: load, iterate, sign-fix or hold.
  always_comb begin
    acc_d     = acc_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mode_d    = mode_q;
    if (load_i) begin
      acc_d     = {{WIDTH{1'b0}}, a_mag_s};
      b_d       = b_mag_s;
      neg_res_d = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_rem_d = signed_i && a_i[WIDTH-1];
      mode_d    = mode_i;
    end else if (step_i) begin
      if (mode_q == MODE_MUL) begin
        acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
      end else if (div_ge_s) begin
        acc_d = {div_diff_s, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else if (fix_i) begin
      acc_d = {hi_fix_o, lo_fix_o};
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= {(2*WIDTH){1'b0}};
      b_q       <= {WIDTH{1'b0}};
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mode_q    <= MODE_MUL;
    end else begin
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mode_q    <= mode_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: accepts ops from decode, iterates the shared
// datapath and produces a single registered HI/LO write-back cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ena,
  muldiv_if.slave  bus
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             hi_we_q, hi_we_d;
  logic             lo_we_q, lo_we_d;
  logic [WIDTH-1:0] hi_data_q, hi_data_d;
  logic [WIDTH-1:0] lo_data_q, lo_data_d;

  logic             accept_s;
  logic             load_s, step_s, fix_s;
  mode_e            mode_s;
  logic [WIDTH-1:0] hi_fix_s, lo_fix_s;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_s),
    .mode_i   (mode_s),
    .signed_i (op_signed(bus.op)),
    .a_i      (bus.rs_val),
    .b_i      (bus.rt_val),
    .step_i   (step_s),
    .fix_i    (fix_s),
    .hi_fix_o (hi_fix_s),
    .lo_fix_o (lo_fix_s)
  );

  // WB doubles as an accept slot so back-to-back issue needs no idle bubble.
  assign accept_s = ena && bus.start && op_legal(bus.op) &&
                    ((state_q == ST_IDLE) || (state_q == ST_WB));

  // Sequencer next-state; with ena low everything holds, including pending strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    dz_d      = dz_q;
    hi_we_d   = hi_we_q;
    lo_we_d   = lo_we_q;
    hi_data_d = hi_data_q;
    lo_data_d = lo_data_q;
    load_s    = 1'b0;
    step_s    = 1'b0;
    fix_s     = 1'b0;
    mode_s    = MODE_MUL;
    if (ena) begin
      done_d  = 1'b0;
      dz_d    = 1'b0;
      hi_we_d = 1'b0;
      lo_we_d = 1'b0;
      case (state_q)
        ST_IDLE, ST_WB: begin
          if (accept_s) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                load_s  = 1'b1;
                mode_s  = MODE_MUL;
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (bus.rt_val == {WIDTH{1'b0}}) begin
                  hi_data_d = bus.rs_val;
                  lo_data_d = {WIDTH{1'b1}};
                  hi_we_d   = 1'b1;
                  lo_we_d   = 1'b1;
                  done_d    = 1'b1;
                  dz_d      = 1'b1;
                  state_d   = ST_WB;
                end else begin
                  load_s  = 1'b1;
                  mode_s  = MODE_DIV;
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = ST_DIV;
                end
              end
              OP_MTHI: begin
                hi_data_d = bus.rs_val;
                hi_we_d   = 1'b1;
                done_d    = 1'b1;
                state_d   = ST_WB;
              end
              OP_MTLO: begin
                lo_data_d = bus.rs_val;
                lo_we_d   = 1'b1;
                done_d    = 1'b1;
                state_d   = ST_WB;
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          step_s = 1'b1;
          if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FIX: begin
          fix_s     = 1'b1;
          hi_data_d = hi_fix_s;
          lo_data_d = lo_fix_s;
          hi_we_d   = 1'b1;
          lo_we_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_WB;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // Control and write-back registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_we_q   <= 1'b0;
      lo_we_q   <= 1'b0;
      hi_data_q <= {WIDTH{1'b0}};
      lo_data_q <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_we_q   <= hi_we_d;
      lo_we_q   <= lo_we_d;
      hi_data_q <= hi_data_d;
      lo_data_q <= lo_data_d;
    end
  end

  // A stalled WB cycle must not write; the strobe reappears once ena returns.
  assign bus.busy     = busy_q;
  assign bus.done     = done_q  & ena;
  assign bus.div_zero = dz_q    & ena;
  assign bus.hi_we    = hi_we_q & ena;
  assign bus.lo_we    = lo_we_q & ena;
  assign bus.hi_data  = hi_data_q;
  assign bus.lo_data  = lo_data_q;

endmodule
